// File: rtl/ipsxe_floating_point_group2_lo_v1_0.sv
// Low-segment stage of the carry-split adder: a+b+c+d-e split into low bits and a signed carry, plus a2_hi+cin1.
// Define IPSXE_FLOATING_POINT_GROUP2_LO_OUTREG_EN to add a third output register stage (latency 3 instead of 2).
module ipsxe_floating_point_group2_lo_v1_0 #(
    parameter int LO_WIDTH = 40,
    parameter int HI_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ce,
    input  logic                i_valid,
    input  logic [LO_WIDTH-1:0] i_seg_a,
    input  logic [LO_WIDTH-1:0] i_seg_b,
    input  logic [LO_WIDTH-1:0] i_seg_c,
    input  logic [LO_WIDTH-1:0] i_seg_d,
    input  logic [LO_WIDTH-1:0] i_seg_e,
    input  logic [HI_WIDTH-1:0] i_a2_hi,
    input  logic                i_cin1,
    output logic                o_valid,
    output logic [LO_WIDTH-1:0] o_group2_lo_lo,
    output logic [4:0]          o_group2_lo_hi,
    output logic [HI_WIDTH-1:0] o_a2_hi_plus_cin1
);

    localparam int SW = LO_WIDTH + 5;

    logic [LO_WIDTH:0]          w_p0;
    logic signed [LO_WIDTH+2:0] w_p1;
    logic [HI_WIDTH-1:0]        w_h;
    logic [SW-1:0]              w_sum;

    logic                       r_v1;
    logic [LO_WIDTH:0]          r_p0;
    logic signed [LO_WIDTH+2:0] r_p1;
    logic [HI_WIDTH-1:0]        r_h1;

    logic                       r_v2;
    logic [LO_WIDTH-1:0]        r_lo2;
    logic [4:0]                 r_hi2;
    logic [HI_WIDTH-1:0]        r_h2;

    assign w_p0 = {1'b0, i_seg_a} + {1'b0, i_seg_b};
    assign w_p1 = $signed({3'b000, i_seg_c}) + $signed({3'b000, i_seg_d}) - $signed({3'b000, i_seg_e});
    assign w_h  = i_a2_hi + {{(HI_WIDTH-1){1'b0}}, i_cin1};

    // p1 may be negative, so it is sign-extended while p0 is zero-extended.
    assign w_sum = {4'b0000, r_p0} + {{2{r_p1[LO_WIDTH+2]}}, r_p1};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v1  <= 1'b0;
            r_p0  <= '0;
            r_p1  <= '0;
            r_h1  <= '0;
            r_v2  <= 1'b0;
            r_lo2 <= '0;
            r_hi2 <= '0;
            r_h2  <= '0;
        end else if (i_ce) begin
            r_v1  <= i_valid;
            r_p0  <= w_p0;
            r_p1  <= w_p1;
            r_h1  <= w_h;
            r_v2  <= r_v1;
            r_lo2 <= w_sum[LO_WIDTH-1:0];
            r_hi2 <= w_sum[SW-1:LO_WIDTH];
            r_h2  <= r_h1;
        end
    end

`ifdef IPSXE_FLOATING_POINT_GROUP2_LO_OUTREG_EN
    logic                r_v3;
    logic [LO_WIDTH-1:0] r_lo3;
    logic [4:0]          r_hi3;
    logic [HI_WIDTH-1:0] r_h3;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v3  <= 1'b0;
            r_lo3 <= '0;
            r_hi3 <= '0;
            r_h3  <= '0;
        end else if (i_ce) begin
            r_v3  <= r_v2;
            r_lo3 <= r_lo2;
            r_hi3 <= r_hi2;
            r_h3  <= r_h2;
        end
    end

    assign o_valid           = r_v3;
    assign o_group2_lo_lo    = r_lo3;
    assign o_group2_lo_hi    = r_hi3;
    assign o_a2_hi_plus_cin1 = r_h3;
`else
    assign o_valid           = r_v2;
    assign o_group2_lo_lo    = r_lo2;
    assign o_group2_lo_hi    = r_hi2;
    assign o_a2_hi_plus_cin1 = r_h2;
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_group2_lo_v1_0.sv
// Randomized self-checking bench for ipsxe_floating_point_group2_lo_v1_0 against a queue-based reference model.
module tb_ipsxe_floating_point_group2_lo_v1_0;

`ifdef IPSXE_FLOATING_POINT_GROUP2_LO_OUTREG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rstN, ce, valid, cin1;
   logic [39:0] segA, segB, segC, segD, segE;
   logic [7:0] a2Hi;
   logic oValid;
   logic [39:0] oLo;
   logic [4:0] oHi;
   logic [7:0] oH;

   typedef struct packed {
      logic        v;
      logic [39:0] lo;
      logic [4:0]  hi;
      logic [7:0]  h;
   } exp_t;

   exp_t hist[$];
   exp_t expOut;
   int numChecks = 0;
   int numFails = 0;

   always #5 clk = ~clk;

   ipsxe_floating_point_group2_lo_v1_0 #(.LO_WIDTH(40), .HI_WIDTH(8)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_ce(ce), .i_valid(valid),
      .i_seg_a(segA), .i_seg_b(segB), .i_seg_c(segC), .i_seg_d(segD), .i_seg_e(segE),
      .i_a2_hi(a2Hi), .i_cin1(cin1),
      .o_valid(oValid), .o_group2_lo_lo(oLo), .o_group2_lo_hi(oHi), .o_a2_hi_plus_cin1(oH)
   );

   // Reference: result of the operand set accepted LAT enabled edges ago, zeros if none since reset.
   function automatic exp_t computeExpected();
      exp_t e;
      longint s;
      s = longint'(segA) + longint'(segB) + longint'(segC) + longint'(segD) - longint'(segE);
      e.v  = valid;
      e.lo = s[39:0];
      s    = s >>> 40;
      e.hi = s[4:0];
      e.h  = a2Hi + {7'd0, cin1};
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [39:0] randSeg();
      logic [63:0] r;
      int mode;
      mode = $urandom_range(0, 5);
      r = {$urandom, $urandom};
      if (mode == 0) r = 64'd0;
      else if (mode == 1) r = 64'hFF_FFFF_FFFF;
      else if (mode == 2) r = 64'd1;
      return r[39:0];
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, then compare at the falling edge.
   task automatic applyStimulus(input logic [39:0] a, input logic [39:0] b, input logic [39:0] c,
                                input logic [39:0] d, input logic [39:0] e, input logic [7:0] hi,
                                input logic cin, input logic v, input logic enable, input logic rn);
      segA = a; segB = b; segC = c; segD = d; segE = e;
      a2Hi = hi; cin1 = cin; valid = v; ce = enable; rstN = rn;
      @(posedge clk);
      if (!rstN) begin
         hist.delete();
      end else if (ce) begin
         hist.push_back(computeExpected());
         if (hist.size() > 8) void'(hist.pop_front());
      end
      if (hist.size() >= LAT) expOut = hist[hist.size() - LAT];
      else expOut = '0;
      @(negedge clk);
      checkOutput("valid", {63'd0, oValid}, {63'd0, expOut.v});
      checkOutput("lo", {24'd0, oLo}, {24'd0, expOut.lo});
      checkOutput("hi", {59'd0, oHi}, {59'd0, expOut.hi});
      checkOutput("hPlusCin", {56'd0, oH}, {56'd0, expOut.h});
   endtask

   task automatic randomCycle(input logic v, input logic enable, input logic rn);
      applyStimulus(randSeg(), randSeg(), randSeg(), randSeg(), randSeg(),
                    8'($urandom), 1'($urandom), v, enable, rn);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) randomCycle(1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      rstN = 1'b0; ce = 1'b1; valid = 1'b0; cin1 = 1'b0;
      segA = '0; segB = '0; segC = '0; segD = '0; segE = '0; a2Hi = '0;
      @(negedge clk);

      // Reset held with random inputs.
      for (int i = 0; i < 3; i++) randomCycle(1'($urandom), 1'b1, 1'b0);

      // Maximum carry, negative carry, high-segment wrap.
      applyStimulus({40{1'b1}}, {40{1'b1}}, {40{1'b1}}, {40{1'b1}}, 40'd0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(40'd0, 40'd0, 40'd0, 40'd0, 40'd1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(40'd5, 40'd6, 40'd7, 40'd8, 40'd9, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(LAT + 1);

      // Stall with two disabled cycles mid-stream.
      randomCycle(1'b1, 1'b1, 1'b1);
      randomCycle(1'b1, 1'b1, 1'b1);
      randomCycle(1'b1, 1'b1, 1'b1);
      randomCycle(1'($urandom), 1'b0, 1'b1);
      randomCycle(1'($urandom), 1'b0, 1'b1);
      randomCycle(1'b1, 1'b1, 1'b1);
      randomCycle(1'b1, 1'b1, 1'b1);
      idle(LAT + 1);

      // Mid-run reset discards in-flight items.
      for (int i = 0; i < 3; i++) randomCycle(1'b1, 1'b1, 1'b1);
      randomCycle(1'b1, 1'b1, 1'b0);
      idle(2);
      for (int i = 0; i < 3; i++) randomCycle(1'b1, 1'b1, 1'b1);
      idle(LAT + 1);

      // Random mix of enable, valid and occasional reset.
      for (int i = 0; i < 400; i++)
         randomCycle(1'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 49) != 0));

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
